// File: rtl/stacktrbuf_ring.sv
// Call-stack trace buffer: circular LIFO of {return_addr, call_addr} entries.
// When full, a push overwrites the oldest entry and sets a sticky overflow flag.
// Supports push, pop, push+pop (tail-call replace), clear, and registered reads
// indexed from the top of stack.
module stacktrbuf_ring #(
    parameter int unsigned abits = 5,
    parameter int unsigned dbits = 128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [dbits-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_rd,
    input  logic [abits-1:0] i_ridx,
    output logic             o_rvalid,
    output logic [dbits-1:0] o_rdata,
    output logic [abits:0]   o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int unsigned Depth = 1 << abits;
    // Count value of a full buffer, i.e. Depth on abits+1 bits.
    localparam logic [abits:0] CntFull = {1'b1, {abits{1'b0}}};
    localparam logic [abits:0] CntOne  = {{abits{1'b0}}, 1'b1};
    localparam logic [abits-1:0] PtrOne = {{(abits-1){1'b0}}, 1'b1};

    logic [abits-1:0] wptr_q, wptr_d;
    logic [abits:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rvalid_q, rvalid_d;
    logic [dbits-1:0] rdata_q, rdata_d;
    logic [dbits-1:0] mem_q [Depth];

    logic             full;
    logic             empty;
    logic [abits-1:0] top_ptr;
    logic [abits-1:0] rd_ptr;
    logic             rd_hit;
    logic             mem_we;
    logic [abits-1:0] mem_waddr;

    assign full    = (cnt_q == CntFull);
    assign empty   = (cnt_q == '0);
    assign top_ptr = wptr_q - PtrOne;
    // Entry k lives at wptr-1-k, modulo Depth.
    assign rd_ptr  = top_ptr - i_ridx;
    assign rd_hit  = ({1'b0, i_ridx} < cnt_q);

    // Next-state for pointer, count, sticky flags and memory write port.
    always_comb begin
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = wptr_q;

        if (i_clr) begin
            wptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else if (i_push && i_pop && !empty) begin
            // Tail call: replace the top entry in place.
            mem_we    = 1'b1;
            mem_waddr = top_ptr;
        end else if (i_push) begin
            // Plain push, or push+pop on an empty buffer.
            mem_we    = 1'b1;
            mem_waddr = wptr_q;
            wptr_d    = wptr_q + PtrOne;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (i_pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                wptr_d = wptr_q - PtrOne;
                cnt_d  = cnt_q - CntOne;
            end
        end
    end

    // Read response is taken from pre-update state (read-before-write).
    always_comb begin
        rvalid_d = i_rd;
        rdata_d  = rdata_q;
        if (i_rd) begin
            rdata_d = rd_hit ? mem_q[rd_ptr] : '0;
        end
    end

    // Control and read-response registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Entry storage; not reset, contents only meaningful below the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst && mem_we) begin
            mem_q[mem_waddr] <= i_wdata;
        end
    end

    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_count     = cnt_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_stacktrbuf_ring.sv
// Directed bench for stacktrbuf_ring: default-size instance for most cases and
// a four-entry instance for wrap/overflow behaviour.
module tb_stacktrbuf_ring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-size instance (abits=5, dbits=128).
    logic         rst, clr, push, pop, rd;
    logic [127:0] wdata;
    logic [4:0]   ridx;
    logic         rvalid, ovf, unf;
    logic [127:0] rdata;
    logic [5:0]   count;

    stacktrbuf_ring u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr       (clr),
        .i_push      (push),
        .i_wdata     (wdata),
        .i_pop       (pop),
        .i_rd        (rd),
        .i_ridx      (ridx),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_count     (count),
        .o_overflow  (ovf),
        .o_underflow (unf)
    );

    // Small instance (abits=2, dbits=16).
    logic        w_rst, w_clr, w_push, w_pop, w_rd;
    logic [15:0] w_wdata;
    logic [1:0]  w_ridx;
    logic        w_rvalid, w_ovf, w_unf;
    logic [15:0] w_rdata;
    logic [2:0]  w_count;

    stacktrbuf_ring #(
        .abits (2),
        .dbits (16)
    ) u_dut_w (
        .i_clk       (clk),
        .i_rst       (w_rst),
        .i_clr       (w_clr),
        .i_push      (w_push),
        .i_wdata     (w_wdata),
        .i_pop       (w_pop),
        .i_rd        (w_rd),
        .i_ridx      (w_ridx),
        .o_rvalid    (w_rvalid),
        .o_rdata     (w_rdata),
        .o_count     (w_count),
        .o_overflow  (w_ovf),
        .o_underflow (w_unf)
    );

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [127:0] ValA = 128'hAAAA_0001_0000_0000_0000_0000_1000_0010;
    localparam logic [127:0] ValB = 128'hBBBB_0002_0000_0000_0000_0000_2000_0020;
    localparam logic [127:0] ValC = 128'hCCCC_0003_0000_0000_0000_0000_3000_0030;
    localparam logic [127:0] ValD = 128'hDDDD_0004_0000_0000_0000_0000_4000_0040;
    localparam logic [127:0] ValX = 128'h5A5A_0005_0000_0000_0000_0000_5000_0050;
    localparam logic [127:0] ValY = 128'h6B6B_0006_0000_0000_0000_0000_6000_0060;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus to the default instance, then sample #1 after the edge.
    task automatic op(input logic o_push, input logic o_pop, input logic o_rd,
                      input logic [4:0] o_idx, input logic [127:0] o_wd,
                      input logic o_clr, input logic o_rst);
        push  = o_push;
        pop   = o_pop;
        rd    = o_rd;
        ridx  = o_idx;
        wdata = o_wd;
        clr   = o_clr;
        rst   = o_rst;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic do_rst();   op(0, 0, 0, 0, '0, 0, 1); endtask
    task automatic do_push(input logic [127:0] v); op(1, 0, 0, 0, v, 0, 0); endtask
    task automatic do_pop();   op(0, 1, 0, 0, '0, 0, 0); endtask
    task automatic do_read(input logic [4:0] k); op(0, 0, 1, k, '0, 0, 0); endtask

    task automatic w_step();
        @(posedge clk);
        #1;
        w_rst = 1'b0; w_push = 1'b0; w_rd = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; rd = 1'b0;
        ridx = '0; wdata = '0;
        w_rst = 1'b0; w_clr = 1'b0; w_push = 1'b0; w_pop = 1'b0; w_rd = 1'b0;
        w_ridx = '0; w_wdata = '0;

        // Reset state.
        do_rst();
        check("rst_count", 128'(count), 0);
        check("rst_rvalid", 128'(rvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_ovf", 128'(ovf), 0);
        check("rst_unf", 128'(unf), 0);

        // Three pushes, then back-to-back reads idx 0..3.
        do_push(ValA);
        do_push(ValB);
        do_push(ValC);
        check("push3_count", 128'(count), 3);
        do_read(0);
        check("rd0_valid", 128'(rvalid), 1);
        check("rd0_data", rdata, ValC);
        do_read(1);
        check("rd1_valid", 128'(rvalid), 1);
        check("rd1_data", rdata, ValB);
        do_read(2);
        check("rd2_valid", 128'(rvalid), 1);
        check("rd2_data", rdata, ValA);
        do_read(3);
        check("rd3_valid", 128'(rvalid), 1);
        check("rd3_data_oob", rdata, 0);
        check("rd_count", 128'(count), 3);

        // Read idx0 together with push D: read sees pre-push top.
        op(1, 0, 1, 0, ValD, 0, 0);
        check("rdpush_data", rdata, ValC);
        check("rdpush_count", 128'(count), 4);
        do_read(0);
        check("rdnext_data", rdata, ValD);
        op(0, 0, 0, 0, '0, 0, 0);
        check("idle_rvalid", 128'(rvalid), 0);
        check("idle_hold", rdata, ValD);

        // Pop behaviour and underflow.
        do_rst();
        do_push(ValA);
        do_push(ValB);
        do_pop();
        check("pop_count", 128'(count), 1);
        do_read(0);
        check("pop_top", rdata, ValA);
        do_pop();
        check("pop2_unf", 128'(unf), 0);
        do_pop();
        check("pop3_count", 128'(count), 0);
        check("pop3_unf", 128'(unf), 1);
        check("pop3_wptr", 128'(u_dut.wptr_q), 0);
        do_push(ValC);
        check("unf_sticky", 128'(unf), 1);
        check("unf_push_count", 128'(count), 1);

        // Tail call replaces the top entry.
        do_rst();
        do_push(ValA);
        do_push(ValB);
        op(1, 1, 0, 0, ValX, 0, 0);
        check("tail_count", 128'(count), 2);
        check("tail_ovf", 128'(ovf), 0);
        do_read(0);
        check("tail_idx0", rdata, ValX);
        do_read(1);
        check("tail_idx1", rdata, ValA);

        // Tail call on empty acts as push, no underflow.
        do_rst();
        op(1, 1, 0, 0, ValY, 0, 0);
        check("tailempty_count", 128'(count), 1);
        check("tailempty_unf", 128'(unf), 0);
        do_read(0);
        check("tailempty_idx0", rdata, ValY);

        // Overflow on the default instance, then clear with a concurrent read.
        do_rst();
        do_pop();
        for (int k = 0; k <= 32; k++) do_push(128'(k));
        check("ovf_count", 128'(count), 32);
        check("ovf_flag", 128'(ovf), 1);
        check("ovf_unf", 128'(unf), 1);
        do_read(31);
        check("ovf_oldest", rdata, 1);
        op(0, 0, 1, 0, '0, 1, 0);
        check("clr_rd_data", rdata, 32);
        check("clr_count", 128'(count), 0);
        check("clr_ovf", 128'(ovf), 0);
        check("clr_unf", 128'(unf), 0);
        do_read(0);
        check("clr_after_valid", 128'(rvalid), 1);
        check("clr_after_data", rdata, 0);

        // Reset during a read drops the response.
        do_push(ValB);
        do_read(0);
        check("prerst_data", rdata, ValB);
        op(0, 0, 1, 0, '0, 0, 1);
        check("rst_rd_rvalid", 128'(rvalid), 0);
        check("rst_rd_rdata", rdata, 0);
        check("rst_rd_count", 128'(count), 0);

        // Wrap on the four-entry instance.
        w_rst = 1'b1;
        w_step();
        for (int k = 0; k < 6; k++) begin
            w_push  = 1'b1;
            w_wdata = 16'(16'hE0 + k);
            w_step();
        end
        check("wrap_count", 128'(w_count), 4);
        check("wrap_ovf", 128'(w_ovf), 1);
        for (int k = 0; k < 4; k++) begin
            w_rd   = 1'b1;
            w_ridx = 2'(k);
            w_step();
            check($sformatf("wrap_idx%0d", k), 128'(w_rdata), 128'(16'hE5 - k));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
